// File: rtl/daq_regmap_pkg.sv
// daq_regmap_pkg: shared response codes, address layout, FSM state types and byte-strobe merge
package daq_regmap_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int ADDR_LSB = 2;
  typedef enum logic [1:0] {WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? data[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/daq_regmap_wr_channel.sv
// daq_regmap_wr_channel: AXI4-Lite AW/W capture, write FSM and write response generation
module daq_regmap_wr_channel
  import daq_regmap_pkg::*;
#(
  parameter int NUM_CFG_REGS = 8
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [29:0] aw_idx,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        wr_fire,
  output logic [29:0] wr_idx,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);
  wr_state_t state, state_nxt;
  logic [29:0] aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic have_aw, have_w;
  assign have_aw = (awvalid && awready) || state == WR_HAVE_AW;
  assign have_w = (wvalid && wready) || state == WR_HAVE_W;
  always_ff @(posedge clk)
    if (!aresetn) state <= WR_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == WR_RESP ? (bready ? WR_IDLE : WR_RESP) :
                (have_aw && have_w) ? WR_RESP :
                have_aw ? WR_HAVE_AW :
                have_w ? WR_HAVE_W : WR_IDLE;
  always_comb begin
    awready = aresetn && (state == WR_IDLE || state == WR_HAVE_W);
    wready = aresetn && (state == WR_IDLE || state == WR_HAVE_AW);
    bvalid = state == WR_RESP;
    wr_fire = state != WR_RESP && state_nxt == WR_RESP;
    wr_idx = state == WR_HAVE_AW ? aw_idx_q : aw_idx;
    wr_data = state == WR_HAVE_W ? wdata_q : wdata;
    wr_strb = state == WR_HAVE_W ? wstrb_q : wstrb;
  end
  always_ff @(posedge clk) begin
    if (awvalid && awready) aw_idx_q <= aw_idx;
    if (wvalid && wready) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end
  always_ff @(posedge clk)
    if (!aresetn) bresp <= RESP_OKAY;
    else if (wr_fire) bresp <= wr_idx < 30'(NUM_CFG_REGS) ? RESP_OKAY : RESP_SLVERR;
endmodule

// File: rtl/daq_axil_regmap.sv
// daq_axil_regmap: AXI4-Lite config/status register map; define DAQ_REGMAP_WSTRB_EN for byte-strobe writes
module daq_axil_regmap
  import daq_regmap_pkg::*;
#(
  parameter int NUM_CFG_REGS = 8,
  parameter int NUM_STATUS_REGS = 4,
  parameter logic [NUM_CFG_REGS*32-1:0] CFG_RESET = '0
) (
  input  logic                                              s_axi_ps_clk,
  input  logic                                              s_axi_ps_aresetn,
  input  logic [31:0]                                       s_axi_ps_awaddr,
  input  logic [2:0]                                        s_axi_ps_awprot,
  input  logic                                              s_axi_ps_awvalid,
  output logic                                              s_axi_ps_awready,
  input  logic [31:0]                                       s_axi_ps_wdata,
  input  logic [3:0]                                        s_axi_ps_wstrb,
  input  logic                                              s_axi_ps_wvalid,
  output logic                                              s_axi_ps_wready,
  output logic [1:0]                                        s_axi_ps_bresp,
  output logic                                              s_axi_ps_bvalid,
  input  logic                                              s_axi_ps_bready,
  input  logic [31:0]                                       s_axi_ps_araddr,
  input  logic [2:0]                                        s_axi_ps_arprot,
  input  logic                                              s_axi_ps_arvalid,
  output logic                                              s_axi_ps_arready,
  output logic [31:0]                                       s_axi_ps_rdata,
  output logic [1:0]                                        s_axi_ps_rresp,
  output logic                                              s_axi_ps_rvalid,
  input  logic                                              s_axi_ps_rready,
  output logic [NUM_CFG_REGS*32-1:0]                        cfg_data,
  output logic [NUM_CFG_REGS-1:0]                           cfg_update,
  input  logic [(NUM_STATUS_REGS > 0 ? NUM_STATUS_REGS : 1)*32-1:0] status_data
);
  logic [31:0] cfg_q [NUM_CFG_REGS];
  logic wr_fire;
  logic [29:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0] wr_strb;
  rd_state_t rd_state, rd_state_nxt;
  logic [29:0] ar_idx;
  logic [31:0] rd_word;
  logic rd_hit, ar_hs;
  logic unused_ok;
  assign unused_ok = ^{s_axi_ps_awaddr[ADDR_LSB-1:0], s_axi_ps_araddr[ADDR_LSB-1:0], s_axi_ps_awprot, s_axi_ps_arprot, wr_strb};
  daq_regmap_wr_channel #(.NUM_CFG_REGS(NUM_CFG_REGS)) u_wr (
    .clk     (s_axi_ps_clk),
    .aresetn (s_axi_ps_aresetn),
    .aw_idx  (s_axi_ps_awaddr[31:ADDR_LSB]),
    .awvalid (s_axi_ps_awvalid),
    .awready (s_axi_ps_awready),
    .wdata   (s_axi_ps_wdata),
    .wstrb   (s_axi_ps_wstrb),
    .wvalid  (s_axi_ps_wvalid),
    .wready  (s_axi_ps_wready),
    .bresp   (s_axi_ps_bresp),
    .bvalid  (s_axi_ps_bvalid),
    .bready  (s_axi_ps_bready),
    .wr_fire (wr_fire),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb)
  );
  always_ff @(posedge s_axi_ps_clk)
    if (!s_axi_ps_aresetn) begin
      cfg_update <= '0;
      for (int i = 0; i < NUM_CFG_REGS; i++) cfg_q[i] <= CFG_RESET[32*i +: 32];
    end else begin
      cfg_update <= '0;
      for (int i = 0; i < NUM_CFG_REGS; i++)
        if (wr_fire && wr_idx == 30'(i)) begin
`ifdef DAQ_REGMAP_WSTRB_EN
          cfg_q[i] <= strb_merge(cfg_q[i], wr_data, wr_strb);
`else
          cfg_q[i] <= wr_data;
`endif
          cfg_update[i] <= 1'b1;
        end
    end
  for (genvar g = 0; g < NUM_CFG_REGS; g++) begin : g_cfg
    assign cfg_data[32*g +: 32] = cfg_q[g];
  end
  assign ar_idx = s_axi_ps_araddr[31:ADDR_LSB];
  assign ar_hs = s_axi_ps_arvalid && s_axi_ps_arready;
  always_comb begin
    rd_word = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < NUM_CFG_REGS; i++)
      if (ar_idx == 30'(i)) begin
        rd_word = cfg_q[i];
        rd_hit = 1'b1;
      end
    for (int i = 0; i < NUM_STATUS_REGS; i++)
      if (ar_idx == 30'(NUM_CFG_REGS + i)) begin
        rd_word = status_data[32*i +: 32];
        rd_hit = 1'b1;
      end
  end
  always_ff @(posedge s_axi_ps_clk)
    if (!s_axi_ps_aresetn) rd_state <= RD_IDLE;
    else rd_state <= rd_state_nxt;
  always_comb
    rd_state_nxt = rd_state == RD_IDLE ? (ar_hs ? RD_RESP : RD_IDLE) : (s_axi_ps_rready ? RD_IDLE : RD_RESP);
  always_comb begin
    s_axi_ps_arready = s_axi_ps_aresetn && rd_state == RD_IDLE;
    s_axi_ps_rvalid = rd_state == RD_RESP;
  end
  always_ff @(posedge s_axi_ps_clk)
    if (!s_axi_ps_aresetn) begin
      s_axi_ps_rdata <= '0;
      s_axi_ps_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_ps_rdata <= rd_word;
      s_axi_ps_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
endmodule

// File: tb/tb_daq_axil_regmap.sv
// tb_daq_axil_regmap: randomized and directed checks of daq_axil_regmap against a word-array model
module tb_daq_axil_regmap;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam logic [NC*32-1:0] CFG_RST = {32'h7700_0007, 32'h6600_0006, 32'h5500_0005, 32'h4400_0004,
                                          32'h3300_0003, 32'h2200_0002, 32'h1100_0001, 32'hA5A5_0000};
  logic clk = 0;
  logic aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [1:0] bresp, rresp;
  logic [NC*32-1:0] cfg_data;
  logic [NC-1:0] cfg_update;
  logic [NS*32-1:0] status_data;
  logic [31:0] exp_cfg [NC];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  daq_axil_regmap #(.NUM_CFG_REGS(NC), .NUM_STATUS_REGS(NS), .CFG_RESET(CFG_RST)) dut (
    .s_axi_ps_clk(clk), .s_axi_ps_aresetn(aresetn),
    .s_axi_ps_awaddr(awaddr), .s_axi_ps_awprot(awprot), .s_axi_ps_awvalid(awvalid), .s_axi_ps_awready(awready),
    .s_axi_ps_wdata(wdata), .s_axi_ps_wstrb(wstrb), .s_axi_ps_wvalid(wvalid), .s_axi_ps_wready(wready),
    .s_axi_ps_bresp(bresp), .s_axi_ps_bvalid(bvalid), .s_axi_ps_bready(bready),
    .s_axi_ps_araddr(araddr), .s_axi_ps_arprot(arprot), .s_axi_ps_arvalid(arvalid), .s_axi_ps_arready(arready),
    .s_axi_ps_rdata(rdata), .s_axi_ps_rresp(rresp), .s_axi_ps_rvalid(rvalid), .s_axi_ps_rready(rready),
    .cfg_data(cfg_data), .cfg_update(cfg_update), .status_data(status_data)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
`ifdef DAQ_REGMAP_WSTRB_EN
    return ({{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & d) | (~{{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} & old);
`else
    return d;
`endif
  endfunction
  function automatic logic [NC*32-1:0] cfg_flat();
    logic [NC*32-1:0] f;
    for (int i = 0; i < NC; i++) f[32*i +: 32] = exp_cfg[i];
    return f;
  endfunction
  task automatic reset_model();
    for (int i = 0; i < NC; i++) exp_cfg[i] = CFG_RST[32*i +: 32];
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int o);
    logic [29:0] idx;
    logic ok;
    logic [NC-1:0] m;
    idx = a[31:2];
    ok = idx < NC;
    m = '0;
    if (ok) m[idx] = 1'b1;
    chk("awready_idle", awready, 1);
    chk("wready_idle", wready, 1);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = (o != 2); wvalid = (o != 1);
    step();
    if (o != 0) begin
      chk("mid_bvalid", bvalid, 0);
      chk("mid_awready", awready, o == 2);
      chk("mid_wready", wready, o == 1);
      awvalid = (o == 2); wvalid = (o == 1);
      step();
    end
    awvalid = 0; wvalid = 0;
    if (ok) exp_cfg[idx] = merge(exp_cfg[idx], d, s);
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, ok ? 2'b00 : 2'b10);
    chk("cfg_update", cfg_update, m);
    chk("cfg_data", cfg_data, cfg_flat());
    chk("awready_resp", awready, 0);
    bready = 1;
    step();
    bready = 0;
    chk("bvalid_clr", bvalid, 0);
    chk("cfg_update_clr", cfg_update, 0);
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] got);
    int k;
    logic [31:0] ed;
    logic [1:0] er;
    k = int'(a[31:2]);
    ed = k < NC ? exp_cfg[k] : k < NC + NS ? status_data[32*(k-NC) +: 32] : 32'h0;
    er = k < NC + NS ? 2'b00 : 2'b10;
    chk("arready_idle", arready, 1);
    araddr = a; arvalid = 1;
    step();
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    chk("arready_resp", arready, 0);
    got = rdata;
    rready = 1;
    step();
    rready = 0;
    chk("rvalid_clr", rvalid, 0);
  endtask
  initial begin
    logic [31:0] got, old, held;
    aresetn = 0; awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; awprot = 0; arprot = 0;
    status_data = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'h1234_5678};
    step();
    step();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_cfg_update", cfg_update, 0);
    chk("rst_cfg_data", cfg_data, CFG_RST);
    reset_model();
    aresetn = 1;
    #1;
    chk("rel_readies", {awready, wready, arready}, 3'b111);
    step();
    wr(32'h04, 32'hDEAD_BEEF, 4'hF, 1);
    chk("deadbeef", cfg_data[63:32], 32'hDEAD_BEEF);
    rd(32'h20, got);
    chk("status0", got, 32'h1234_5678);
    wr(32'h30, 32'h0BAD_0BAD, 4'hF, 2);
    rd(32'h30, got);
    chk("oor_rdata", got, 0);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF, 0);
    wr(32'h00, 32'h0000_0000, 4'b0101, 2);
`ifdef DAQ_REGMAP_WSTRB_EN
    chk("strb_reg0", cfg_data[31:0], 32'hFF00_FF00);
`else
    chk("strb_reg0", cfg_data[31:0], 32'h0000_0000);
`endif
    wr(32'h1E, 32'h5555_AAAA, 4'hF, 0);
    rd(32'h1F, got);
    old = exp_cfg[2];
    awaddr = 32'h08; wdata = 32'h0F0F_1234; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h08; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_cfg[2] = merge(exp_cfg[2], 32'h0F0F_1234, 4'hF);
    chk("same_edge_rdata", rdata, old);
    chk("same_edge_cfg", cfg_data, cfg_flat());
    bready = 1; rready = 1;
    step();
    bready = 0; rready = 0;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      status_data = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) wr(a, $urandom, 4'($urandom), $urandom_range(0, 2));
      else rd(a, got);
    end
    awaddr = 32'h0C; wdata = 32'h3C3C_3C3C; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    step();
    awvalid = 0; wvalid = 0;
    araddr = 32'h14; arvalid = 1;
    held = exp_cfg[5];
    step();
    arvalid = 0;
    for (int n = 0; n < 5; n++) begin
      chk("hold_bvalid", bvalid, 1);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata", rdata, held);
      chk("hold_bresp", bresp, 2'b00);
      step();
    end
    aresetn = 0;
    step();
    chk("rst2_readies", {awready, wready, arready}, 3'b000);
    chk("rst2_valids", {bvalid, rvalid}, 2'b00);
    chk("rst2_resps", {bresp, rresp}, 4'b0000);
    chk("rst2_rdata", rdata, 0);
    chk("rst2_cfg_update", cfg_update, 0);
    chk("rst2_cfg_data", cfg_data, CFG_RST);
    reset_model();
    aresetn = 1;
    #1;
    chk("rel2_readies", {awready, wready, arready}, 3'b111);
    step();
    rd(32'h0C, got);
    chk("reg3_after_rst", got, CFG_RST[127:96]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
